// File: rtl/pr_enc_dig8_pkg.sv
// Shared widths and index codes for the 8-to-3 priority encoder.
package pr_enc_dig8_pkg;

  localparam int N_IN   = 8;
  localparam int CODE_W = 3;

  localparam logic [CODE_W-1:0] IDX0 = 3'd0;
  localparam logic [CODE_W-1:0] IDX1 = 3'd1;
  localparam logic [CODE_W-1:0] IDX2 = 3'd2;
  localparam logic [CODE_W-1:0] IDX3 = 3'd3;
  localparam logic [CODE_W-1:0] IDX4 = 3'd4;
  localparam logic [CODE_W-1:0] IDX5 = 3'd5;
  localparam logic [CODE_W-1:0] IDX6 = 3'd6;
  localparam logic [CODE_W-1:0] IDX7 = 3'd7;

endpackage

// File: rtl/pr_enc_comb8.sv
// Combinational 8-to-3 priority encoder; the highest asserted index wins.
module pr_enc_comb8
  import pr_enc_dig8_pkg::*;
(
  input  logic [N_IN-1:0]   d,
  output logic [CODE_W-1:0] code,
  output logic              any
);

  // Descending chain so lines below the winner never reach the outputs, even when X.
  always_comb begin
    code = IDX0;
    any  = 1'b1;
    if (d[7])      code = IDX7;
    else if (d[6]) code = IDX6;
    else if (d[5]) code = IDX5;
    else if (d[4]) code = IDX4;
    else if (d[3]) code = IDX3;
    else if (d[2]) code = IDX2;
    else if (d[1]) code = IDX1;
    else if (d[0]) code = IDX0;
    else           any  = 1'b0;
  end

endmodule

// File: rtl/pr_enc_dig8.sv
// Registered 8-to-3 priority encoder with a valid flag separating idle from index 0.
module pr_enc_dig8
  import pr_enc_dig8_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d0,
  input  logic d1,
  input  logic d2,
  input  logic d3,
  input  logic d4,
  input  logic d5,
  input  logic d6,
  input  logic d7,
  output logic a,
  output logic b,
  output logic c,
  output logic valid
);

  logic [N_IN-1:0]   d_vec;
  logic [CODE_W-1:0] code;
  logic              any;

  assign d_vec = {d7, d6, d5, d4, d3, d2, d1, d0};

  pr_enc_comb8 u_comb (
    .d    (d_vec),
    .code (code),
    .any  (any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {a, b, c} <= IDX0;
      valid     <= 1'b0;
    end else begin
      {a, b, c} <= code;
      valid     <= any;
    end
  end

endmodule

// File: tb/tb_pr_enc_dig8.sv
// Directed self-checking bench for pr_enc_dig8; outputs sampled on the falling edge.
module tb_pr_enc_dig8;

  logic clk;
  logic rst;
  logic d0, d1, d2, d3, d4, d5, d6, d7;
  logic a, b, c, valid;

  int checks = 0;
  int errors = 0;

  pr_enc_dig8 dut (
    .clk   (clk),
    .rst   (rst),
    .d0    (d0),
    .d1    (d1),
    .d2    (d2),
    .d3    (d3),
    .d4    (d4),
    .d5    (d5),
    .d6    (d6),
    .d7    (d7),
    .a     (a),
    .b     (b),
    .c     (c),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares {a,b,c,valid}; !== also flags X/Z on the outputs.
  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got abc_v=%b required %b", tag, obs, exp);
    end
  endtask

  task automatic set_d(input logic [7:0] v);
    {d7, d6, d5, d4, d3, d2, d1, d0} = v;
  endtask

  initial begin
    logic [7:0] v;
    logic [2:0] kk;

    rst = 1'b1;
    set_d(8'h00);
    repeat (2) @(negedge clk);
    check("reset_hold", {a, b, c, valid}, 4'b0000);
    rst = 1'b0;

    set_d(8'h80);
    @(negedge clk);
    check("d7_pre_reset", {a, b, c, valid}, 4'b1111);

    // Asynchronous reset mid-cycle, no clock edge in between.
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset", {a, b, c, valid}, 4'b0000);
    repeat (2) @(negedge clk);
    check("reset_held_edges", {a, b, c, valid}, 4'b0000);
    rst = 1'b0;
    @(negedge clk);
    check("first_after_reset", {a, b, c, valid}, 4'b1111);

    for (int k = 0; k < 8; k++) begin
      v = 8'h00;
      v[k] = 1'b1;
      set_d(v);
      @(negedge clk);
      kk = k[2:0];
      check($sformatf("onehot_d%0d", k), {a, b, c, valid}, {kk, 1'b1});
    end

    for (int k = 0; k < 8; k++) begin
      v = 8'h00;
      v[k] = 1'b1;
      for (int j = 0; j < k; j++) v[j] = 1'bx;
      set_d(v);
      @(negedge clk);
      kk = k[2:0];
      check($sformatf("x_lower_d%0d", k), {a, b, c, valid}, {kk, 1'b1});
    end

    set_d(8'b0100_0101);
    @(negedge clk);
    check("multi_d6_d2_d0", {a, b, c, valid}, 4'b1101);
    set_d(8'b0000_1010);
    @(negedge clk);
    check("multi_d3_d1", {a, b, c, valid}, 4'b0111);

    set_d(8'h00);
    @(negedge clk);
    check("idle", {a, b, c, valid}, 4'b0000);
    set_d(8'h01);
    @(negedge clk);
    check("d0_only", {a, b, c, valid}, 4'b0001);

    // Inputs change just after an edge; outputs must hold until the next edge.
    set_d(8'h20);
    @(negedge clk);
    check("latency_setup", {a, b, c, valid}, 4'b1011);
    @(posedge clk);
    #1 set_d(8'h08);
    #2 check("latency_hold", {a, b, c, valid}, 4'b1011);
    @(negedge clk);
    check("latency_hold_neg", {a, b, c, valid}, 4'b1011);
    @(negedge clk);
    check("latency_update", {a, b, c, valid}, 4'b0111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
